// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: capture sequencer and single-port SRAM arbiter for ADC sample capture
module adc_capture_ctrl #(
  parameter int AW   = 15,
  parameter int DW   = 10,
  parameter int DLYW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            rf_capture_start,
  input  logic            rf_capture_abort,
  input  logic            rf_trig_mode,
  input  logic [DLYW-1:0] rf_trig_delay,
  input  logic [AW-1:0]   rf_capture_len,
  input  logic            trig_in,
  input  logic            adc_valid,
  input  logic [DW-1:0]   adc_data,
  input  logic            rd_req,
  input  logic [AW-1:0]   rd_addr,
  output logic            rd_ack,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic            wr_done,
  output logic            busy,
  output logic [2:0]      ctrl_state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRIG = 3'd1,
    DELAY     = 3'd2,
    CAPTURE   = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   waddr_q, waddr_d, len_q, len_d;
  logic [DLYW-1:0] dly_cnt_q, dly_cnt_d, dly_q, dly_d;
  logic            trig_d_q, wr_done_q, wr_done_d, wr_issue, trig_edge;
  logic            mem_en_q, mem_we_q, mem_en_d, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  assign trig_edge  = trig_in & ~trig_d_q;
  // A read may only take the port when capture cannot claim the next-cycle slot.
  assign rd_ack     = rd_req && state_q != CAPTURE && !wr_issue;
  assign busy       = state_q inside {WAIT_TRIG, DELAY, CAPTURE};
  assign ctrl_state = state_q;
  assign wr_done    = wr_done_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Next-state logic: abort beats start, start beats the per-state sequencing.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    len_d     = len_q;
    dly_d     = dly_q;
    dly_cnt_d = dly_cnt_q;
    wr_done_d = wr_done_q;
    wr_issue  = 1'b0;
    if (rf_capture_abort) begin
      state_d   = IDLE;
      wr_done_d = 1'b0;
    end else if (rf_capture_start) begin
      wr_done_d = 1'b0;
      waddr_d   = '0;
      dly_cnt_d = '0;
      len_d     = rf_capture_len;
      dly_d     = rf_trig_delay;
      state_d   = rf_trig_mode ? WAIT_TRIG : (rf_trig_delay != '0 ? DELAY : CAPTURE);
    end else begin
      case (state_q)
        WAIT_TRIG: if (trig_edge) begin
          dly_d     = rf_trig_delay;
          dly_cnt_d = '0;
          state_d   = rf_trig_delay != '0 ? DELAY : CAPTURE;
        end
        DELAY: if (dly_cnt_q == dly_q - DLYW'(1)) state_d = CAPTURE;
               else dly_cnt_d = dly_cnt_q + DLYW'(1);
        CAPTURE: if (adc_valid) begin
          wr_issue = 1'b1;
          if (waddr_q == len_q) begin
            state_d   = DONE;
            wr_done_d = 1'b1;
          end else waddr_d = waddr_q + AW'(1);
        end
        default: ;
      endcase
    end
    mem_en_d    = wr_issue | rd_ack;
    mem_we_d    = wr_issue;
    mem_addr_d  = wr_issue ? waddr_q : (rd_ack ? rd_addr : mem_addr_q);
    mem_wdata_d = wr_issue ? adc_data : mem_wdata_q;
  end

  // State and SRAM port registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      waddr_q     <= '0;
      len_q       <= '0;
      dly_q       <= '0;
      dly_cnt_q   <= '0;
      trig_d_q    <= 1'b0;
      wr_done_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      len_q       <= len_d;
      dly_q       <= dly_d;
      dly_cnt_q   <= dly_cnt_d;
      trig_d_q    <= trig_in;
      wr_done_q   <= wr_done_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: directed and randomized checks of capture sequencing and read arbitration
module tb_adc_capture_ctrl;
  localparam int AW = 15, DW = 10, DLYW = 16, N = 200;

  logic            clk = 1'b0, rstn = 1'b0;
  logic            rf_capture_start = 1'b0, rf_capture_abort = 1'b0, rf_trig_mode = 1'b0;
  logic [DLYW-1:0] rf_trig_delay = '0;
  logic [AW-1:0]   rf_capture_len = '0, rd_addr = '0;
  logic            trig_in = 1'b0, adc_valid = 1'b0, rd_req = 1'b0;
  logic [DW-1:0]   adc_data = '0;
  logic            rd_ack, mem_en, mem_we, wr_done, busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [2:0]      ctrl_state;

  int n_cmp = 0, n_err = 0;

  logic          vld_a[N], trg_a[N];
  logic [DW-1:0] dat_a[N];
  logic          o_we[N], o_en[N], o_done[N], o_busy[N];
  logic [AW-1:0] o_addr[N];
  logic [DW-1:0] o_wd[N];
  logic [2:0]    o_st[N];

  adc_capture_ctrl #(.AW(AW), .DW(DW), .DLYW(DLYW)) dut (
    .clk(clk), .rstn(rstn),
    .rf_capture_start(rf_capture_start), .rf_capture_abort(rf_capture_abort),
    .rf_trig_mode(rf_trig_mode), .rf_trig_delay(rf_trig_delay), .rf_capture_len(rf_capture_len),
    .trig_in(trig_in), .adc_valid(adc_valid), .adc_data(adc_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .wr_done(wr_done), .busy(busy), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rf_capture_start = 1'b0;
    rf_capture_abort = 1'b0;
    adc_valid = 1'b0;
    rd_req = 1'b0;
  endtask

  // One capture with random valid gaps/data; expectations derived from cycle arithmetic.
  task automatic run_cap(input bit mode, input int dly, input int len, input bit tprev, input bit full);
    int te, cs, cl, w, j, e_st;
    bit e_we;
    te = $urandom_range(3, 20);
    for (int k = 0; k < N; k++) begin
      vld_a[k] = full ? 1'b1 : 1'($urandom_range(0, 1));
      dat_a[k] = DW'($urandom);
      trg_a[k] = (k < 2) ? tprev : (k >= te);
    end
    idle_in();
    trig_in = tprev;
    tick();
    for (int k = 0; k < N; k++) begin
      rf_capture_start = (k == 0);
      rf_trig_mode     = mode;
      rf_capture_len   = (k == 0) ? AW'(len) : AW'($urandom);
      rf_trig_delay    = (k == 0 || mode) ? DLYW'(dly) : DLYW'($urandom);
      trig_in   = trg_a[k];
      adc_valid = vld_a[k];
      adc_data  = dat_a[k];
      tick();
      o_we[k] = mem_we; o_en[k] = mem_en; o_addr[k] = mem_addr; o_wd[k] = mem_wdata;
      o_done[k] = wr_done; o_busy[k] = busy; o_st[k] = ctrl_state;
    end
    idle_in();
    te = N;
    for (int k = 1; k < N; k++) if (te == N && trg_a[k] && !trg_a[k-1]) te = k;
    cs = mode ? te + 1 + dly : 1 + dly;
    cl = N;
    w  = 0;
    for (int k = 0; k < N; k++) begin
      e_we = k >= cs && cl == N && vld_a[k];
      chk("we", 32'(o_we[k]), 32'(e_we));
      chk("en", 32'(o_en[k]), 32'(e_we));
      if (e_we) begin
        chk("waddr", 32'(o_addr[k]), 32'(w));
        chk("wdata", 32'(o_wd[k]), 32'(dat_a[k]));
        if (w == len) cl = k;
        w++;
      end
      chk("done", 32'(o_done[k]), 32'(cl <= k));
      chk("busy", 32'(o_busy[k]), 32'(k < cl));
      j = k + 1;
      e_st = (j > cl) ? 4 : (j >= cs) ? 3 : (j >= cs - dly) ? 2 : 1;
      chk("state", 32'(o_st[k]), 32'(e_st));
    end
    chk("cap_finished", 32'(cl < N), 32'(1));
  endtask

  initial begin
    int nw, seq_bad, dn, acked;
    logic [AW-1:0] last;
    logic prev_done, ackk;
    idle_in();
    tick(); tick();
    chk("rst_state", 32'(ctrl_state), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(wr_done), 0);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_ack", 32'(rd_ack), 0);
    rstn = 1'b1;
    tick();
    // read while idle is granted at once
    rd_req = 1'b1; rd_addr = AW'(5);
    #1;
    chk("idle_ack", 32'(rd_ack), 1);
    tick();
    rd_req = 1'b0;
    chk("idle_rd_en", 32'(mem_en), 1);
    chk("idle_rd_we", 32'(mem_we), 0);
    chk("idle_rd_addr", 32'(mem_addr), 5);
    tick();
    chk("noacc_en", 32'(mem_en), 0);
    chk("noacc_hold", 32'(mem_addr), 5);
    // immediate capture of 8 samples, then trigger+delay with trigger high before arm
    run_cap(1'b0, 0, 7, 1'b0, 1'b1);
    run_cap(1'b1, 5, 3, 1'b1, 1'b1);
    for (int s = 0; s < 8; s++)
      run_cap(1'($urandom_range(0, 1)), $urandom_range(0, 12), $urandom_range(0, 20),
              1'($urandom_range(0, 1)), 1'b0);
    // read requested mid-capture waits for DONE
    idle_in();
    rf_trig_mode = 1'b0; rf_trig_delay = '0; rf_capture_len = AW'(9);
    acked = 0;
    for (int k = 0; k < 14; k++) begin
      rf_capture_start = (k == 0);
      adc_valid = 1'b1;
      adc_data = DW'(k + 200);
      rd_req = (k >= 3) && acked == 0;
      rd_addr = AW'('h12);
      #1;
      if (rd_req) chk("arb_ack", 32'(rd_ack), 32'(k == 11));
      ackk = rd_ack;
      if (rd_ack) acked = 1;
      tick();
      if (ackk) begin
        chk("arb_en", 32'(mem_en), 1);
        chk("arb_we", 32'(mem_we), 0);
        chk("arb_addr", 32'(mem_addr), 'h12);
      end
    end
    chk("arb_granted", 32'(acked), 1);
    // abort on the third write, then restart
    idle_in();
    rf_capture_len = AW'(15);
    for (int k = 0; k < 6; k++) begin
      rf_capture_start = (k == 0);
      rf_capture_abort = (k == 3);
      adc_valid = 1'b1;
      adc_data = DW'(k + 100);
      tick();
      chk("abort_we", 32'(mem_we), 32'(k == 1 || k == 2));
      if (k == 1 || k == 2) chk("abort_addr", 32'(mem_addr), 32'(k - 1));
      if (k >= 3) begin
        chk("abort_state", 32'(ctrl_state), 0);
        chk("abort_done", 32'(wr_done), 0);
      end
    end
    for (int k = 0; k < 18; k++) begin
      rf_capture_abort = 1'b0;
      rf_capture_start = (k == 0);
      adc_valid = 1'b1;
      adc_data = DW'(k + 300);
      tick();
      if (k == 1) begin
        chk("restart_we", 32'(mem_we), 1);
        chk("restart_addr", 32'(mem_addr), 0);
      end
    end
    chk("restart_done", 32'(wr_done), 1);
    idle_in();
    rf_capture_abort = 1'b1;
    tick();
    rf_capture_abort = 1'b0;
    chk("abort_done_clr", 32'(wr_done), 0);
    chk("abort_done_state", 32'(ctrl_state), 0);
    // async reset in the middle of DELAY
    rf_trig_delay = DLYW'(10); rf_capture_len = AW'(3); rf_capture_start = 1'b1;
    tick();
    rf_capture_start = 1'b0;
    tick(); tick(); tick();
    chk("dly_state", 32'(ctrl_state), 2);
    #2 rstn = 1'b0;
    #1;
    chk("arst_state", 32'(ctrl_state), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_en", 32'(mem_en), 0);
    chk("arst_addr", 32'(mem_addr), 0);
    chk("arst_wdata", 32'(mem_wdata), 0);
    chk("arst_done", 32'(wr_done), 0);
    tick();
    rstn = 1'b1;
    tick();
    // start while DONE restarts at address 0
    rf_trig_delay = '0; rf_capture_len = AW'(2);
    for (int k = 0; k < 6; k++) begin
      rf_capture_start = (k == 0);
      adc_valid = 1'b1;
      adc_data = DW'(k + 400);
      tick();
    end
    chk("pre_done", 32'(wr_done), 1);
    rf_capture_start = 1'b1;
    tick();
    rf_capture_start = 1'b0;
    chk("redo_done_clr", 32'(wr_done), 0);
    chk("redo_state", 32'(ctrl_state), 3);
    tick();
    chk("redo_we", 32'(mem_we), 1);
    chk("redo_addr", 32'(mem_addr), 0);
    // full-depth capture with adc_valid toggling
    idle_in();
    rf_capture_len = '1;
    rf_capture_start = 1'b1;
    tick();
    rf_capture_start = 1'b0;
    nw = 0; seq_bad = 0; dn = 0; last = '0; prev_done = 1'b0;
    for (int k = 0; k < 65550; k++) begin
      adc_valid = (k % 2 == 0);
      adc_data = DW'(k);
      tick();
      if (mem_we) begin
        if (mem_addr != AW'(nw)) seq_bad++;
        last = mem_addr;
        nw++;
      end
      if (wr_done && !prev_done) dn++;
      prev_done = wr_done;
    end
    idle_in();
    chk("full_writes", 32'(nw), 32768);
    chk("full_last", 32'(last), 'h7FFF);
    chk("full_seq", 32'(seq_bad), 0);
    chk("full_done_once", 32'(dn), 1);
    chk("full_state", 32'(ctrl_state), 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
